pc_src_ctrl: RTL and testbench

- Multicycle sequencer that drives the 2-bit PC-source selector and the PC/EPC write enables of the MIPS datapath.
- Sequences each instruction's PC update: fetch increment, branch/jump target, overflow/invalid-opcode exception vector.
- Sits between main control and the PC-source mux. Owns PC-update timing and the exception cause register.

---
 rtl/pc_src_ctrl.sv | 176 +++++++++++++++++
 tb/tb_pc_src_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_src_ctrl.sv
// pc_src_ctrl: multicycle PC-update sequencer for the MIPS datapath.
// Drives the PC-source selector plus the PC/IR/EPC write enables, and owns
// the exception cause register.
// Optional build macro: PC_SRC_CTRL_PERF_EN adds retired/exception counters.
module pc_src_ctrl #(
  parameter int unsigned EXEC_MAX_CYC = 8,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_branch,
  input  logic             is_jump,
  input  logic             bad_opcode,
  input  logic             alu_done,
  input  logic             alu_zero,
  input  logic             alu_ovf,
  output logic [1:0]       pc_src,
  output logic             pc_write,
  output logic             ir_write,
  output logic             epc_write,
  output logic [1:0]       exc_cause,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] exc_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_TARGET,
    S_EXC_SAVE,
    S_EXC_VEC,
    S_DONE
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(EXEC_MAX_CYC - 1);

  state_t     state, state_nxt;
  logic       br_flag, jp_flag;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic [1:0] cause_nxt;

  // State, wait counter and cause register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      exc_cause <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      exc_cause <= cause_nxt;
    end
  end

  // Branch/jump decode flags, captured while in DECODE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      br_flag <= 1'b0;
      jp_flag <= 1'b0;
    end else if (state == S_DECODE) begin
      br_flag <= is_branch;
      jp_flag <= is_jump;
    end
  end

  // Next-state, wait-counter and cause update
  // Cause is cleared on the transition into FETCH so it already reads 00
  // during the FETCH cycle.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    cause_nxt    = exc_cause;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_FETCH;
          cause_nxt = '0;
        end
      end
      S_FETCH: state_nxt = S_DECODE;
      S_DECODE: begin
        if (bad_opcode) begin
          cause_nxt = 2'b10;
          state_nxt = S_EXC_SAVE;
        end else begin
          wait_cnt_nxt = '0;
          state_nxt    = S_EXEC;
        end
      end
      S_EXEC: begin
        if (alu_done) begin
          if (alu_ovf) begin
            cause_nxt = 2'b01;
            state_nxt = S_EXC_SAVE;
          end else if (jp_flag || (br_flag && alu_zero)) begin
            state_nxt = S_TARGET;
          end else begin
            state_nxt = S_DONE;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          cause_nxt = 2'b11;
          state_nxt = S_EXC_SAVE;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      S_TARGET:   state_nxt = S_DONE;
      S_EXC_SAVE: state_nxt = S_EXC_VEC;
      S_EXC_VEC:  state_nxt = S_DONE;
      S_DONE: begin
        if (start) begin
          state_nxt = S_FETCH;
          cause_nxt = '0;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Moore output decode from the state register
  always_comb begin
    pc_src    = 2'b00;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    epc_write = 1'b0;
    done      = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_FETCH: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        ir_write = 1'b1;
      end
      S_TARGET: begin
        pc_src   = 2'b01;
        pc_write = 1'b1;
      end
      S_EXC_SAVE: epc_write = 1'b1;
      S_EXC_VEC: begin
        pc_src   = 2'b11;
        pc_write = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

`ifdef PC_SRC_CTRL_PERF_EN
  logic [CNT_W-1:0] ret_q, exc_q;

  // Retired and exception counters, wrapping, cleared by reset only
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ret_q <= '0;
      exc_q <= '0;
    end else begin
      if (state == S_DONE) ret_q <= ret_q + CNT_W'(1);
      if ((state_nxt == S_EXC_SAVE) && (state != S_EXC_SAVE)) exc_q <= exc_q + CNT_W'(1);
    end
  end

  assign retired_cnt = ret_q;
  assign exc_cnt     = exc_q;
`else
  assign retired_cnt = '0;
  assign exc_cnt     = '0;
`endif

endmodule

// File: tb/tb_pc_src_ctrl.sv
// tb_pc_src_ctrl: randomized bench for pc_src_ctrl against a per-instruction
// action-list model (FETCH, DECODE, EXEC waits, TARGET/EXC, DONE).
module tb_pc_src_ctrl;

  localparam int MAX = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0, is_branch = 1'b0, is_jump = 1'b0, bad_opcode = 1'b0;
  logic        alu_done = 1'b0, alu_zero = 1'b0, alu_ovf = 1'b0;
  logic [1:0]  pc_src, exc_cause;
  logic        pc_write, ir_write, epc_write, done, busy;
  logic [31:0] retired_cnt, exc_cnt;

  int total = 0;
  int bad = 0;
  int m_ret = 0;
  int m_exc = 0;
  logic [1:0] last_cause = 2'b00;

  pc_src_ctrl #(.EXEC_MAX_CYC(MAX), .CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .is_branch(is_branch),
    .is_jump(is_jump), .bad_opcode(bad_opcode), .alu_done(alu_done),
    .alu_zero(alu_zero), .alu_ovf(alu_ovf), .pc_src(pc_src),
    .pc_write(pc_write), .ir_write(ir_write), .epc_write(epc_write),
    .exc_cause(exc_cause), .done(done), .busy(busy),
    .retired_cnt(retired_cnt), .exc_cnt(exc_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_cnt();
`ifdef PC_SRC_CTRL_PERF_EN
    check("retired_cnt", retired_cnt, m_ret);
    check("exc_cnt", exc_cnt, m_exc);
`else
    check("retired_cnt", retired_cnt, 0);
    check("exc_cnt", exc_cnt, 0);
`endif
  endtask

  task automatic idle_cycle();
    start = 1'b0;
    @(posedge clk); @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_pc_src", pc_src, 0);
    check("idle_pc_write", pc_write, 0);
    check("idle_done", done, 0);
    check("idle_cause", exc_cause, last_cause);
  endtask

  // One instruction. d = EXEC cycle on which alu_done rises (0 or >MAX: never).
  // Entered at a negedge while the DUT sits in IDLE or DONE.
  task automatic run_instr(input bit br, input bit jp, input bit bop, input bit zero,
                           input bit ovf, input int d, input bit chain, input int abort_k);
    logic [5:0] exp_q[$];   // {done, epc_write, ir_write, pc_write, pc_src}
    logic [1:0] cause_q[$];
    logic [1:0] cause_e;
    bit         exc, tgt;
    int         n;
    logic [5:0] e;
    int         len;

    exc = 0; tgt = 0; cause_e = 2'b00;
    n = (d >= 1 && d <= MAX) ? d : MAX;
    exp_q.push_back(6'b001110); cause_q.push_back(2'b00);
    exp_q.push_back(6'b000000); cause_q.push_back(2'b00);
    if (bop) begin
      exc = 1; cause_e = 2'b10;
    end else begin
      for (int i = 0; i < n; i++) begin
        exp_q.push_back(6'b000000); cause_q.push_back(2'b00);
      end
      if (!(d >= 1 && d <= MAX)) begin
        exc = 1; cause_e = 2'b11;
      end else if (ovf) begin
        exc = 1; cause_e = 2'b01;
      end else if (jp || (br && zero)) begin
        tgt = 1;
      end
    end
    if (exc) begin
      exp_q.push_back(6'b010000); cause_q.push_back(cause_e);
      exp_q.push_back(6'b000111); cause_q.push_back(cause_e);
    end
    if (tgt) begin
      exp_q.push_back(6'b000101); cause_q.push_back(2'b00);
    end
    exp_q.push_back(6'b100000); cause_q.push_back(cause_e);
    len = exp_q.size();

    start = 1'b1;
    is_branch = 1'($urandom); is_jump = 1'($urandom); bad_opcode = 1'($urandom);
    alu_done = 1'($urandom); alu_zero = 1'($urandom); alu_ovf = 1'($urandom);

    for (int k = 1; k <= len; k++) begin
      @(posedge clk); @(negedge clk);
      e = exp_q[k-1];
      check("pc_src", pc_src, e[1:0]);
      check("pc_write", pc_write, e[2]);
      check("ir_write", ir_write, e[3]);
      check("epc_write", epc_write, e[4]);
      check("done", done, e[5]);
      check("busy", busy, 1);
      if (k >= 2) check("exc_cause", exc_cause, cause_q[k-1]);
      if (k == abort_k) begin
        reset_n = 1'b0;
        start = 1'b0;
        #1;
        check("rst_pc_src", pc_src, 0);
        check("rst_pc_write", pc_write, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cause", exc_cause, 0);
        m_ret = 0; m_exc = 0; last_cause = 2'b00;
        check_cnt();
        @(posedge clk); @(negedge clk);
        check("rst_hold_pc_write", pc_write, 0);
        check("rst_hold_busy", busy, 0);
        reset_n = 1'b1;
        return;
      end
      start = (k == len) ? chain : 1'($urandom);
      is_branch  = (k == 2) ? br  : 1'($urandom);
      is_jump    = (k == 2) ? jp  : 1'($urandom);
      bad_opcode = (k == 2) ? bop : 1'($urandom);
      if (!bop && k >= 3 && k <= 2 + n) begin
        alu_done = (k == 2 + d);
        alu_zero = (k == 2 + d) ? zero : 1'($urandom);
        alu_ovf  = (k == 2 + d) ? ovf  : 1'($urandom);
      end else begin
        alu_done = 1'($urandom); alu_zero = 1'($urandom); alu_ovf = 1'($urandom);
      end
    end
    m_ret++;
    if (exc) m_exc++;
    last_cause = cause_e;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit prev_chain;
    bit c;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_pc_src", pc_src, 0);
    check("reset_pc_write", pc_write, 0);
    check("reset_ir_write", ir_write, 0);
    check("reset_epc_write", epc_write, 0);
    check("reset_done", done, 0);
    check("reset_busy", busy, 0);
    check("reset_cause", exc_cause, 0);
    check_cnt();
    reset_n = 1'b1;
    @(posedge clk); @(negedge clk);

    // directed cases: sequential, taken/untaken branch, ovf+jump, bad opcode
    run_instr(0, 0, 0, 0, 0, 1, 0, 0);   idle_cycle();
    run_instr(1, 0, 0, 1, 0, 1, 0, 0);   idle_cycle();
    run_instr(1, 0, 0, 0, 0, 1, 0, 0);   idle_cycle();
    run_instr(0, 1, 0, 0, 1, 2, 0, 0);   idle_cycle();
    run_instr(1, 1, 1, 1, 1, 1, 0, 0);   idle_cycle();
    // timeout, then alu_done exactly on the last allowed EXEC cycle
    run_instr(0, 0, 0, 0, 0, 0, 0, 0);   idle_cycle();
    run_instr(0, 0, 0, 0, 0, MAX, 0, 0); idle_cycle();
    // held start: back-to-back instructions
    run_instr(0, 0, 0, 0, 0, 1, 1, 0);
    run_instr(0, 1, 0, 0, 0, 3, 0, 0);   idle_cycle();
    check_cnt();
    // reset pulsed in TARGET, then three instructions with one overflow
    run_instr(1, 0, 0, 1, 0, 1, 0, 4);   idle_cycle();
    run_instr(0, 0, 0, 0, 0, 1, 0, 0);   idle_cycle();
    run_instr(0, 0, 0, 0, 1, 1, 0, 0);   idle_cycle();
    run_instr(1, 0, 0, 1, 0, 2, 0, 0);   idle_cycle();
    check_cnt();

    prev_chain = 0;
    for (int i = 0; i < 60; i++) begin
      if (!prev_chain) idle_cycle();
      c = 1'($urandom);
      run_instr(1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
                1'($urandom), ($urandom_range(0, 3) == 0),
                $urandom_range(0, MAX + 1), c, 0);
      prev_chain = c;
    end
    idle_cycle();
    check_cnt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
